// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and pipeline-register layouts for the execute stage.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_t;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'h0,
    C_LE     = 4'h1,
    C_L      = 4'h2,
    C_E      = 4'h3,
    C_NE     = 4'h4,
    C_GE     = 4'h5,
    C_G      = 4'h6
  } cond_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alufun_t;

  typedef enum logic [2:0] {
    S_BUB = 3'd0,
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_t;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    stat_t      stat;
    icode_t     icode;
    logic [3:0] ifun;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } e_ctrl_t;

  typedef struct packed {
    stat_t      stat;
    icode_t     icode;
    logic       cnd;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } m_ctrl_t;

  localparam e_ctrl_t E_BUBBLE = '{stat: S_BUB, icode: I_NOP, ifun: 4'h0,
                                   dst_e: RNONE, dst_m: RNONE};
  localparam m_ctrl_t M_BUBBLE = '{stat: S_BUB, icode: I_NOP, cnd: 1'b0,
                                   dst_e: RNONE, dst_m: RNONE};

  // Undefined OPq function codes fall back to ADD; decode has already flagged them INS.
  function automatic alufun_t alu_select(input icode_t icode, input logic [3:0] ifun);
    if (icode == I_OPQ && ifun < 4'd4) return alufun_t'(ifun[1:0]);
    return ALU_ADD;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational Y86-64 ALU: ADD/SUB/AND/XOR plus next ZF/SF/OF values.
module exec_alu
  import y86_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [DW-1:0] alu_a,
  input  logic [DW-1:0] alu_b,
  input  alufun_t       fun,
  output logic [DW-1:0] r,
  output logic          zf,
  output logic          sf,
  output logic          of
);

  logic [DW-1:0] diff;
  logic [DW-1:0] carry;
  logic [DW-1:0] sum;
  logic          cin;

  // Ripple subtractor B + ~A + 1; overflow is the carry into vs. out of the sign bit.
  always_comb begin
    diff  = '0;
    carry = '0;
    cin   = 1'b1;
    for (int i = 0; i < DW; i++) begin
      diff[i]  = alu_b[i] ^ ~alu_a[i] ^ cin;
      carry[i] = (alu_b[i] & ~alu_a[i]) | (cin & (alu_b[i] ^ ~alu_a[i]));
      cin      = carry[i];
    end
  end

  assign sum = alu_b + alu_a;

  always_comb begin
    r  = '0;
    of = 1'b0;
    case (fun)
      ALU_ADD: begin
        r  = sum;
        of = (alu_a[DW-1] == alu_b[DW-1]) && (sum[DW-1] != alu_a[DW-1]);
      end
      ALU_SUB: begin
        r  = diff;
        of = carry[DW-2] ^ carry[DW-1];
      end
      ALU_AND: r = alu_a & alu_b;
      ALU_XOR: r = alu_a ^ alu_b;
      default: r = sum;
    endcase
  end

  assign zf = (r == '0);
  assign sf = r[DW-1];

endmodule

// File: rtl/pipe_execute.sv
// Y86-64 execute stage: E register, ALU, condition codes, branch/cmov condition, M register.
// Optional EXEC_STAT_CNT_EN builds a counter of instructions passing from E into M.
module pipe_execute
  import y86_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          e_bubble,
  input  logic          m_bubble,
  input  logic          mw_exc,
  input  logic [2:0]    d_stat,
  input  logic [3:0]    d_icode,
  input  logic [3:0]    d_ifun,
  input  logic [DW-1:0] d_valC,
  input  logic [DW-1:0] d_valA,
  input  logic [DW-1:0] d_valB,
  input  logic [3:0]    d_dstE,
  input  logic [3:0]    d_dstM,
  output logic [DW-1:0] e_valE,
  output logic [3:0]    e_dstE,
  output logic [2:0]    M_stat,
  output logic [3:0]    M_icode,
  output logic          M_Cnd,
  output logic [DW-1:0] M_valE,
  output logic [DW-1:0] M_valA,
  output logic [3:0]    M_dstE,
  output logic [3:0]    M_dstM,
  output logic [31:0]   exec_cnt
);

  e_ctrl_t       e_reg;
  logic [DW-1:0] e_valc, e_vala, e_valb;
  m_ctrl_t       m_reg;
  logic [DW-1:0] m_vale, m_vala;

  logic          cc_zf, cc_sf, cc_of;
  logic [DW-1:0] alu_a, alu_b, alu_r;
  alufun_t       alu_fun;
  logic          alu_zf, alu_sf, alu_of;
  logic          cnd, set_cc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_reg  <= E_BUBBLE;
      e_valc <= '0;
      e_vala <= '0;
      e_valb <= '0;
    end else if (e_bubble) begin
      e_reg  <= E_BUBBLE;
      e_valc <= '0;
      e_vala <= '0;
      e_valb <= '0;
    end else begin
      e_reg  <= '{stat: stat_t'(d_stat), icode: icode_t'(d_icode), ifun: d_ifun,
                 dst_e: d_dstE, dst_m: d_dstM};
      e_valc <= d_valC;
      e_vala <= d_valA;
      e_valb <= d_valB;
    end
  end

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (e_reg.icode)
      I_RRMOVQ, I_OPQ:               alu_a = e_vala;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:  alu_a = e_valc;
      I_CALL, I_PUSHQ:               alu_a = ~DW'(7);
      I_RET, I_POPQ:                 alu_a = DW'(8);
      default:                       alu_a = '0;
    endcase
    case (e_reg.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = e_valb;
      default:                                                   alu_b = '0;
    endcase
  end

  assign alu_fun = alu_select(e_reg.icode, e_reg.ifun);

  exec_alu #(.DW(DW)) u_alu (
    .alu_a (alu_a),
    .alu_b (alu_b),
    .fun   (alu_fun),
    .r     (alu_r),
    .zf    (alu_zf),
    .sf    (alu_sf),
    .of    (alu_of)
  );

  // Condition is evaluated on the flags as they stand before this instruction's CC write.
  always_comb begin
    cnd = 1'b0;
    case (e_reg.ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = (cc_sf ^ cc_of) | cc_zf;
      C_L:      cnd = cc_sf ^ cc_of;
      C_E:      cnd = cc_zf;
      C_NE:     cnd = ~cc_zf;
      C_GE:     cnd = ~(cc_sf ^ cc_of);
      C_G:      cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
      default:  cnd = 1'b0;
    endcase
  end

  assign set_cc = (e_reg.icode == I_OPQ) && !mw_exc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (set_cc) begin
      cc_zf <= alu_zf;
      cc_sf <= alu_sf;
      cc_of <= alu_of;
    end
  end

  assign e_valE = alu_r;
  assign e_dstE = (e_reg.icode == I_RRMOVQ && !cnd) ? RNONE : e_reg.dst_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg  <= M_BUBBLE;
      m_vale <= '0;
      m_vala <= '0;
    end else if (m_bubble) begin
      m_reg  <= M_BUBBLE;
      m_vale <= '0;
      m_vala <= '0;
    end else begin
      m_reg  <= '{stat: e_reg.stat, icode: e_reg.icode, cnd: cnd,
                 dst_e: e_dstE, dst_m: e_reg.dst_m};
      m_vale <= alu_r;
      m_vala <= e_vala;
    end
  end

  assign M_stat  = m_reg.stat;
  assign M_icode = m_reg.icode;
  assign M_Cnd   = m_reg.cnd;
  assign M_valE  = m_vale;
  assign M_valA  = m_vala;
  assign M_dstE  = m_reg.dst_e;
  assign M_dstM  = m_reg.dst_m;

`ifdef EXEC_STAT_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!m_bubble && e_reg.stat != S_BUB) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign exec_cnt = cnt_q;
`else
  assign exec_cnt = '0;
`endif

endmodule

// File: doc/pipe_execute.md
Name: pipe_execute

Overview:
Execute stage of the Y86-64 five-stage pipeline. Holds the E pipeline register (decode to execute), computes the ALU result and the condition flags (ZF, SF, OF), and evaluates the branch/cmov condition. Produces the M pipeline register (execute to memory) and drives the e_valE/e_dstE forwarding path back to decode.

Parameters:
DW, 64, datapath width for valC/valA/valB/valE.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
e_bubble  in  1  load bubble into E register at next edge
m_bubble  in  1  load bubble into M register at next edge
mw_exc  in  1  exception status (ADR/INS/HLT) present in M or W stage
d_stat  in  3  decode status
d_icode  in  4  instruction code
d_ifun  in  4  function code
d_valC  in  DW  immediate / displacement
d_valA  in  DW  operand A
d_valB  in  DW  operand B
d_dstE  in  4  ALU destination register id
d_dstM  in  4  memory destination register id
e_valE  out  DW  combinational ALU result (forwarding)
e_dstE  out  4  combinational effective dstE (forwarding)
M_stat  out  3  registered status
M_icode  out  4  registered icode
M_Cnd  out  1  registered condition result
M_valE  out  DW  registered ALU result
M_valA  out  DW  registered valA (store data / return address)
M_dstE  out  4  registered dstE
M_dstM  out  4  registered dstM
exec_cnt  out  32  retired-through-execute counter (see Optional Feature)

Behaviour:
- Encodings: icode HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B. Stat: BUB=0, AOK=1, HLT=2, ADR=3, INS=4. RNONE=F.
- Bubble value of E and M: stat=BUB, icode=NOP, ifun=0, dst=RNONE, data=0, Cnd=0.
- Reset (async, rst_n=0): E and M take their bubble values; CC set to ZF=1, SF=0, OF=0; exec_cnt=0. Reset asserted mid-operation discards in-flight instructions with no partial update.
- Latency: d_* captured into E at edge N; the ALU is combinational on E; M loads at edge N+1. CC also updates at edge N+1.
- aluA: valA for RRMOVQ/OPQ; valC for IRMOVQ/RMMOVQ/MRMOVQ; -8 for CALL/PUSHQ; +8 for RET/POPQ; 0 otherwise.
- aluB: valB for RMMOVQ/MRMOVQ/OPQ/CALL/PUSHQ/RET/POPQ; 0 for RRMOVQ/IRMOVQ and otherwise.
- alufun: ifun when icode=OPQ, else ADD. Functions: 0 ADD B+A, 1 SUB B-A, 2 AND, 3 XOR. ifun>3 with OPQ is treated as ADD (decode already flags INS).
- Arithmetic is DW-bit two's complement with silent wrap.
  - ADD OF = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - SUB OF = (A[msb]!=B[msb]) & (R[msb]!=B[msb]).
  - AND/XOR OF = 0.
- ZF = (R==0). SF = R[msb].
- set_cc = (E_icode==OPQ) & ~mw_exc. CC is written only when set_cc=1, and is unaffected by bubbles on E or M.
- Cnd by ifun, using the current (pre-update) CC: 0 = 1; 1 = (SF^OF)|ZF; 2 = SF^OF; 3 = ZF; 4 = ~ZF; 5 = ~(SF^OF); 6 = ~(SF^OF)&~ZF; others = 0.
- e_dstE = RNONE when icode=RRMOVQ and Cnd=0; otherwise E_dstE.
- Simultaneous events:
  - m_bubble overrides normal M load.
  - e_bubble overrides normal E load.
  - Both asserted: both stages bubble in the same cycle.
  - Once M_stat is HLT, ADR or INS, CC stays frozen via mw_exc, which is driven by the controller.

Optional Feature:
EXEC_STAT_CNT_EN
- Defined: exec_cnt increments by 1 on each edge at which M loads a non-bubble instruction (m_bubble=0 and E_stat!=BUB); it wraps at 2^32 and is cleared by reset.
- Undefined: exec_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Package y86_pkg holds the icode, ifun, stat and alufun enumerations, the RNONE constant, and a packed E/M pipeline-register struct typedef.
- One sub-module, exec_alu, is combinational: it takes aluA, aluB and alufun and returns the result R plus the ZF/SF/OF next values.
- exec_alu's SUB path uses the team's 64-bit ripple subtractor, so OF equals carry[62]^carry[63].

Test Plan:
1. Reset check: hold rst_n=0 for 2 cycles, then release -> M_icode=1, M_stat=0, M_dstE=F, exec_cnt=0; a following jle sees Cnd=1 because ZF=1.
2. OPQ SUB with valB=3, valA=5 -> M_valE=FFFF_FFFF_FFFF_FFFE, CC ZF=0 SF=1 OF=0; a following JXX ifun=2 (jl) gives M_Cnd=1.
3. OPQ SUB with valB=8000_0000_0000_0000, valA=1 -> M_valE=7FFF_FFFF_FFFF_FFFF, OF=1, SF=0; a following jl gives Cnd=1 and jle gives Cnd=1.
4. OPQ ADD 1+1 (CC becomes 0/0/0), then RRMOVQ ifun=1 with dstE=3 -> e_dstE=F, M_dstE=F, M_Cnd=0.
5. PUSHQ with valB=0x100 -> M_valE=0xF8. POPQ with valB=0x100 -> M_valE=0x108.
6. OPQ XOR 5^5 with mw_exc=1 -> M_valE=0 but CC unchanged. Then with e_bubble=1 and m_bubble=1 -> M bubble; exec_cnt does not increment when EXEC_STAT_CNT_EN is defined.
